fpu_result_arbiter: RTL

Collects results from the FPU's functional units (min/max selector, adder, multiplier, divider/sqrt, …) over their valid/ready result ports and serialises them into one result stream for integer/FP writeback. Round-robin arbitration, a 2-entry result FIFO and a sticky exception-flag accumulator feeding `fcsr.fflags`. Sits between the FPU unit outputs and the writeback stage.

---
 rtl/fpu_result_arbiter_pkg.sv | 20 ++
 rtl/fpu_result_arbiter_rr.sv | 31 +++
 rtl/fpu_result_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/fpu_result_arbiter_pkg.sv
// Shared types and constants for the FPU result arbiter.
package FPU_pkg;

  // Exception flag bit positions inside the 5-bit fflags field
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int FLEN   = 32;
  localparam int NFLAGS = 5;

  // One unit result as stored in the result FIFO
  typedef struct packed {
    logic [FLEN-1:0]   float;
    logic [NFLAGS-1:0] flags;
  } fpu_result_t;

endpackage

// File: rtl/fpu_result_arbiter_rr.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  int idx;

  // Walk requesters starting at ptr; latch the first one found
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_result_arbiter.sv
// Serialises FPU unit results into one writeback stream: round-robin
// grant, small result FIFO, sticky exception flags for fcsr.fflags.
module fpu_result_arbiter
  import FPU_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_UNITS-1:0]            valid_in,
  output logic [N_UNITS-1:0]            ready_out,
  input  logic [N_UNITS-1:0][FLEN-1:0]  float_in,
  input  logic [N_UNITS-1:0][NFLAGS-1:0] flags_in,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [FLEN-1:0]               float_out,
  output logic [NFLAGS-1:0]             flags_out,
  input  logic                          fflags_clr,
  output logic [NFLAGS-1:0]             fflags
);

  localparam int IW = $clog2(N_UNITS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0]       rr_q, g_idx;
  logic [N_UNITS-1:0]  grant;
  logic                g_vld;
  fpu_result_t         mem_q [DEPTH];
  fpu_result_t         head, wdata;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [NFLAGS-1:0]   fflags_q;
  logic                full, empty, push, pop;

  rr_arbiter #(.N(N_UNITS)) u_arb (
    .req       (valid_in),
    .ptr       (rr_q),
    .grant     (grant),
    .grant_idx (g_idx),
    .grant_vld (g_vld)
  );

  // ready_out only sees valid_in and registered count, never ready_in
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign ready_out = (reset || full) ? '0 : grant;
  assign push      = g_vld && !full && !reset;
  assign pop       = !empty && ready_in;

  assign wdata     = '{float: float_in[g_idx], flags: flags_in[g_idx]};
  assign head      = mem_q[rd_ptr_q];
  assign valid_out = !empty;
  assign float_out = empty ? '0 : head.float;
  assign flags_out = empty ? '0 : head.flags;
  assign fflags    = fflags_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO storage; contents are masked by count so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  // FIFO pointers, occupancy and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        rr_q     <= (g_idx == IW'(N_UNITS - 1)) ? '0 : g_idx + 1'b1;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flags: a clear in the same cycle as an accept keeps the new flags
  always_ff @(posedge clk) begin
    if (reset)           fflags_q <= '0;
    else if (push)       fflags_q <= fflags_clr ? wdata.flags : (fflags_q | wdata.flags);
    else if (fflags_clr) fflags_q <= '0;
  end

endmodule
